// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-memory requests for loads/stores, waits for
// the acknowledge with a bounded timeout, and registers the MEM/WB outputs.
module mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_M,
  input  logic [31:0] ALU_result_M,
  input  logic [31:0] wdata_M,
  input  logic [31:0] PC_M,
  input  logic [1:0]  wb_ctrl_M,
  input  logic        mem_read_M,
  input  logic        mem_write_M,
  input  logic [2:0]  funct3_M,
  input  logic [4:0]  rd_M,
  input  logic        reg_write_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_M,
  output logic        valid_W,
  output logic [31:0] ALU_result_W,
  output logic [31:0] Rdata_W,
  output logic [31:0] PC_W,
  output logic [1:0]  wb_ctrl_W,
  output logic [4:0]  rd_W,
  output logic        reg_write_W,
  output logic        mem_err_W
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               valid_q, valid_d;
  logic [31:0]        alu_q, alu_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        pc_q, pc_d;
  logic [1:0]         wb_q, wb_d;
  logic [4:0]         rd_q, rd_d;
  logic               regwr_q, regwr_d;
  logic               err_q, err_d;

  logic               access_c, legal_f3_c, misaligned_c, bad_acc_c, legal_acc_c;
  logic               timeout_c, err_c;
  logic [1:0]         lane_c;
  logic [31:0]        shifted_c, load_c;

  // Access classification
  always_comb begin
    access_c = valid_M & (mem_read_M | mem_write_M);
    lane_c   = ALU_result_M[1:0];
    if (mem_write_M) begin
      legal_f3_c = (funct3_M == 3'b000) || (funct3_M == 3'b001) || (funct3_M == 3'b010);
    end else begin
      legal_f3_c = (funct3_M == 3'b000) || (funct3_M == 3'b001) || (funct3_M == 3'b010) ||
                   (funct3_M == 3'b100) || (funct3_M == 3'b101);
    end
    misaligned_c = ((funct3_M[1:0] == 2'b01) && lane_c[0]) ||
                   ((funct3_M[1:0] == 2'b10) && (lane_c != 2'b00));
    bad_acc_c    = access_c & (!legal_f3_c | misaligned_c);
    legal_acc_c  = access_c & !bad_acc_c;
  end

  // Timeout fires on the ACK_TIMEOUT-th WAIT cycle (counter starts at 0 on entry)
  assign timeout_c = (state_q == S_WAIT) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  // FSM next state and handshake outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dmem_req = 1'b0;
    stall_M  = 1'b0;
    case (state_q)
      S_IDLE: begin
        dmem_req = legal_acc_c;
        stall_M  = legal_acc_c & !dmem_ack;
        if (legal_acc_c && !dmem_ack) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        dmem_req = 1'b1;
        stall_M  = !dmem_ack & !timeout_c;
        if (dmem_ack || timeout_c) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst_n) begin
      dmem_req = 1'b0;
      stall_M  = 1'b0;
    end
  end

  // Store formatting: address, lane strobes and replicated data
  always_comb begin
    dmem_addr  = {ALU_result_M[31:2], 2'b00};
    dmem_we    = mem_write_M;
    dmem_wstrb = 4'b0000;
    dmem_wdata = wdata_M;
    if (mem_write_M) begin
      case (funct3_M[1:0])
        2'b00: begin
          dmem_wstrb = 4'b0001 << lane_c;
          dmem_wdata = {4{wdata_M[7:0]}};
        end
        2'b01: begin
          dmem_wstrb = 4'b0011 << lane_c;
          dmem_wdata = {2{wdata_M[15:0]}};
        end
        default: dmem_wstrb = 4'b1111;
      endcase
    end
  end

  // Load extraction from the addressed lane
  always_comb begin
    shifted_c = dmem_rdata >> {lane_c, 3'b000};
    case (funct3_M)
      3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b010:  load_c = dmem_rdata;
      3'b100:  load_c = {24'h0, shifted_c[7:0]};
      3'b101:  load_c = {16'h0, shifted_c[15:0]};
      default: load_c = 32'h0;
    endcase
  end

  // MEM/WB next values; a stall loads a bubble and holds the data fields
  always_comb begin
    err_c   = bad_acc_c | (timeout_c & !dmem_ack);
    valid_d = 1'b0;
    regwr_d = 1'b0;
    err_d   = 1'b0;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    pc_d    = pc_q;
    wb_d    = wb_q;
    rd_d    = rd_q;
    if (!stall_M) begin
      valid_d = valid_M;
      regwr_d = reg_write_M & valid_M & !err_c;
      err_d   = err_c;
      alu_d   = ALU_result_M;
      rdata_d = (access_c && mem_read_M && !err_c) ? load_c : 32'h0;
      pc_d    = PC_M;
      wb_d    = wb_ctrl_M;
      rd_d    = rd_M;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      alu_q   <= '0;
      rdata_q <= '0;
      pc_q    <= '0;
      wb_q    <= '0;
      rd_q    <= '0;
      regwr_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      pc_q    <= pc_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      regwr_q <= regwr_d;
      err_q   <= err_d;
    end
  end

  assign valid_W      = valid_q;
  assign ALU_result_W = alu_q;
  assign Rdata_W      = rdata_q;
  assign PC_W         = pc_q;
  assign wb_ctrl_W    = wb_q;
  assign rd_W         = rd_q;
  assign reg_write_W  = regwr_q;
  assign mem_err_W    = err_q;

endmodule
